axi_stream_header_arbiter: RTL

// Round-robin arbiter that shares one axi_stream_insert_header instance among NUM_SRC

---
 rtl/axi_stream_header_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter sharing one header-insert port among NUM_SRC requesters.
// Ports: per-source hdr valid/data/keep/ready in; valid/data/keep_insert out; mon_* taps; status out.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              s_valid_hdr,
  input  logic [NUM_SRC*DATA_WD-1:0]      s_data_hdr,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_hdr,
  output logic [NUM_SRC-1:0]              s_ready_hdr,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  input  logic                            ready_insert,
  input  logic                            mon_valid_out,
  input  logic                            mon_ready_out,
  input  logic                            mon_last_out,
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic                            hdr_keep_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    FRAME = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SRC_WD-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SRC_WD-1:0]       gid_q, gid_d;
  logic [DATA_WD-1:0]      data_q, data_d;
  logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
  logic                    err_q, err_d;

  logic [SRC_WD:0]         idx;
  logic [SRC_WD-1:0]       gnt_idx;
  logic                    gnt_found;
  logic                    cap;
  logic                    last_hs;
  logic [DATA_WD-1:0]      sel_data;
  logic [DATA_BYTE_WD-1:0] sel_keep;
  logic [DATA_BYTE_WD-1:0] keep_inc;
  logic                    keep_ok;

  // First requester at or above rr_ptr, wrapping at NUM_SRC.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, rr_ptr_q} + (SRC_WD+1)'(i);
      if (idx >= (SRC_WD+1)'(NUM_SRC)) begin
        idx = idx - (SRC_WD+1)'(NUM_SRC);
      end
      if (!gnt_found && s_valid_hdr[idx[SRC_WD-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[SRC_WD-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == SRC_WD'(i)) begin
        sel_data = s_data_hdr[i*DATA_WD +: DATA_WD];
        sel_keep = s_keep_hdr[i*DATA_BYTE_WD +: DATA_BYTE_WD];
      end
    end
  end

  // Legal keep is a non-empty run of ones starting at byte 0.
  assign keep_inc = sel_keep + DATA_BYTE_WD'(1);
  assign keep_ok  = (|sel_keep) && ((sel_keep & keep_inc) == '0);

  assign cap     = (state_q == IDLE) && gnt_found;
  assign last_hs = mon_valid_out && mon_ready_out && mon_last_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = HDR;
          gid_d   = gnt_idx;
          data_d  = sel_data;
          keep_d  = sel_keep;
          err_d   = !keep_ok;
        end
      end
      HDR: begin
        if (ready_insert) state_d = FRAME;
      end
      FRAME: begin
        if (last_hs) begin
          state_d  = IDLE;
          rr_ptr_d = (gid_q == SRC_WD'(NUM_SRC-1))
                   ? '0 : gid_q + SRC_WD'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept is gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    s_ready_hdr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_ready_hdr[i] = rst_n && cap && (gnt_idx == SRC_WD'(i));
    end
    valid_insert = (state_q == HDR);
    busy         = (state_q != IDLE);
    data_insert  = data_q;
    keep_insert  = keep_q;
    grant_id     = gid_q;
    hdr_keep_err = err_q;
  end

endmodule
